// File: rtl/slave_mem_responder.sv
// Memory-backed slave responder for the 2x2 cross-bar req/ack protocol.
// Captures one request, waits WAIT_CYCLES, accesses the word array, then pulses s_ack.
module slave_mem_responder #(
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned AW          = $clog2(DEPTH),
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_req,
    input  logic [31:0]      s_addr,
    input  logic             s_cmd,
    input  logic [31:0]      s_wdata,
    output logic             s_ack,
    output logic [31:0]      s_rdata,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] rd_count,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic               cmd_q, cmd_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [CNT_W-1:0]   wr_count_q, wr_count_d;
    logic [CNT_W-1:0]   rd_count_q, rd_count_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;

    logic [31:0]        mem_q [DEPTH];

    // Access operands: straight from the bus when the access happens on the capture edge.
    logic               do_access;
    logic [AW-1:0]      acc_idx;
    logic               acc_cmd;
    logic [31:0]        acc_wdata;
    logic               mem_we;

    // Upper address bits are decoded by the cross-bar and deliberately ignored here.
    logic               unused_addr;
    assign unused_addr = ^s_addr[31:AW];

    // Next-state, access strobe and registered-output computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        cmd_d      = cmd_q;
        wdata_d    = wdata_q;
        do_access  = 1'b0;
        acc_idx    = idx_q;
        acc_cmd    = cmd_q;
        acc_wdata  = wdata_q;

        unique case (state_q)
            StIdle: begin
                acc_idx   = s_addr[AW-1:0];
                acc_cmd   = s_cmd;
                acc_wdata = s_wdata;
                if (s_req) begin
                    idx_d   = s_addr[AW-1:0];
                    cmd_d   = s_cmd;
                    wdata_d = s_wdata;
                    cnt_d   = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d   = StAck;
                        do_access = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!s_req) begin
                    // Master withdrew the request: abort with no side effects.
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d   = StAck;
                        do_access = 1'b1;
                    end
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        mem_we     = do_access & acc_cmd;
        rdata_d    = (do_access && !acc_cmd) ? mem_q[acc_idx] : rdata_q;
        wr_count_d = mem_we ? wr_count_q + CNT_W'(1) : wr_count_q;
        rd_count_d = (do_access && !acc_cmd) ? rd_count_q + CNT_W'(1) : rd_count_q;
        ack_d      = (state_d == StAck);
        busy_d     = (state_d != StIdle);
    end

    // Control state, holding registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            cmd_q      <= 1'b0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            wr_count_q <= '0;
            rd_count_q <= '0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            cmd_q      <= cmd_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    // Word array; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    assign s_ack    = ack_q;
    assign s_rdata  = rdata_q;
    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_slave_mem_responder.sv
// Bench for slave_mem_responder: three instances (WAIT_CYCLES 0, 1, 3) against a word-array model.
module tb_slave_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req   [3];
    logic        cmd   [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic        ack   [3];
    logic [31:0] rdata [3];
    logic [15:0] wr_cnt [3];
    logic [15:0] rd_cnt [3];
    logic        busy  [3];

    always #5 clk = ~clk;

    slave_mem_responder #(.DEPTH(32), .WAIT_CYCLES(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .reset(reset), .s_req(req[0]), .s_addr(addr[0]), .s_cmd(cmd[0]),
        .s_wdata(wdata[0]), .s_ack(ack[0]), .s_rdata(rdata[0]), .wr_count(wr_cnt[0]),
        .rd_count(rd_cnt[0]), .busy(busy[0])
    );
    slave_mem_responder #(.DEPTH(32), .WAIT_CYCLES(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .reset(reset), .s_req(req[1]), .s_addr(addr[1]), .s_cmd(cmd[1]),
        .s_wdata(wdata[1]), .s_ack(ack[1]), .s_rdata(rdata[1]), .wr_count(wr_cnt[1]),
        .rd_count(rd_cnt[1]), .busy(busy[1])
    );
    slave_mem_responder #(.DEPTH(32), .WAIT_CYCLES(3), .CNT_W(16)) u_dut2 (
        .clk(clk), .reset(reset), .s_req(req[2]), .s_addr(addr[2]), .s_cmd(cmd[2]),
        .s_wdata(wdata[2]), .s_ack(ack[2]), .s_rdata(rdata[2]), .wr_count(wr_cnt[2]),
        .rd_count(rd_cnt[2]), .busy(busy[2])
    );

    // Reference model
    int unsigned wait_of [3] = '{0, 1, 3};
    logic [31:0] mmem    [3][32];
    logic [15:0] m_wr    [3];
    logic [15:0] m_rd    [3];
    logic [31:0] m_rdata [3];
    bit          held    [3];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_wr[k] = 16'd0; m_rd[k] = 16'd0; m_rdata[k] = 32'd0; held[k] = 1'b0;
        end
    endtask

    // One transaction, entered at a negedge; hold keeps s_req high for a back-to-back follower.
    task automatic txn(input int k, input bit c, input logic [31:0] a, input logic [31:0] d,
                       input bit hold);
        int n;
        int exp_n;
        int idx;
        idx   = int'(a % 32);
        exp_n = int'(wait_of[k]) + 1 + (held[k] ? 1 : 0);
        req[k] = 1'b1; cmd[k] = c; addr[k] = a; wdata[k] = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack[k] !== 1'b1 && n < 40);
        check($sformatf("latency%0d", k), n, exp_n);
        if (c) begin
            mmem[k][idx] = d;
            m_wr[k]++;
        end else begin
            m_rdata[k] = mmem[k][idx];
            m_rd[k]++;
        end
        check($sformatf("rdata%0d", k), rdata[k], m_rdata[k]);
        check($sformatf("wr_count%0d", k), wr_cnt[k], m_wr[k]);
        check($sformatf("rd_count%0d", k), rd_cnt[k], m_rd[k]);
        held[k] = hold;
        if (!hold) begin
            req[k] = 1'b0; cmd[k] = 1'($urandom); wdata[k] = $urandom;
            @(negedge clk);
            check($sformatf("ack_pulse%0d", k), ack[k], 1'b0);
            check($sformatf("busy_idle%0d", k), busy[k], 1'b0);
            check($sformatf("rdata_hold%0d", k), rdata[k], m_rdata[k]);
        end
    endtask

    initial begin
        int n;
        bit c;
        logic [31:0] old7;

        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; cmd[k] = 1'b0; addr[k] = 32'd0; wdata[k] = 32'd0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_ack", ack[k], 1'b0);
            check("rst_rdata", rdata[k], 32'd0);
            check("rst_wr", wr_cnt[k], 32'd0);
            check("rst_rd", rd_cnt[k], 32'd0);
            check("rst_busy", busy[k], 1'b0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Write then read back one word with one wait state
        txn(1, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 1'b0);
        txn(1, 1'b0, 32'h0000_0005, 32'h0, 1'b0);
        check("rw5_data", rdata[1], 32'hDEAD_BEEF);

        // Fill every word; back-to-back with s_req held high; random upper address bits
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 32; i++) begin
                txn(k, 1'b1, ($urandom & 32'hFFFF_FFE0) | 32'(i), $urandom, i < 31);
            end
        end
        for (int i = 0; i < 4; i++) begin
            txn(0, 1'b0, 32'(i), 32'h0, i < 3);
        end

        // Abort during WAIT on a write to idx 7
        old7 = mmem[2][7];
        req[2] = 1'b1; cmd[2] = 1'b1; addr[2] = 32'd7; wdata[2] = ~old7;
        @(negedge clk);
        check("abort_busy", busy[2], 1'b1);
        @(negedge clk);
        check("abort_ack_pre", ack[2], 1'b0);
        req[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_ack", ack[2], 1'b0);
        end
        check("abort_busy_end", busy[2], 1'b0);
        check("abort_wr", wr_cnt[2], m_wr[2]);
        txn(2, 1'b0, 32'd7, 32'h0, 1'b0);
        check("abort_mem7", rdata[2], old7);

        // Aliased address
        txn(1, 1'b1, 32'h8000_0023, 32'h1234_5678, 1'b0);
        txn(1, 1'b0, 32'h0000_0003, 32'h0, 1'b0);
        check("alias", rdata[1], 32'h1234_5678);

        // Reset asserted during ACK of a read
        req[1] = 1'b1; cmd[1] = 1'b0; addr[1] = 32'd9;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack[1] !== 1'b1 && n < 40);
        check("rstack_seen", ack[1], 1'b1);
        reset = 1'b1;
        #1;
        check("rstack_ack", ack[1], 1'b0);
        check("rstack_rdata", rdata[1], 32'd0);
        check("rstack_wr", wr_cnt[1], 32'd0);
        check("rstack_rd", rd_cnt[1], 32'd0);
        check("rstack_busy", busy[1], 1'b0);
        model_reset();
        req[1] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        txn(1, 1'b0, 32'd2, 32'h0, 1'b0);

        // Write counter wrap
        force u_dut1.wr_count_q = 16'hFFFF;
        @(negedge clk);
        release u_dut1.wr_count_q;
        m_wr[1] = 16'hFFFF;
        @(negedge clk);
        check("wr_preload", wr_cnt[1], 32'h0000_FFFF);
        txn(1, 1'b1, 32'd11, $urandom, 1'b0);
        check("wr_wrap", wr_cnt[1], 32'h0000_0000);

        // Random traffic on every instance
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 50; i++) begin
                c = 1'($urandom);
                txn(k, c, $urandom, $urandom, (i < 49) ? 1'($urandom) : 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
